seq_div_r32m: RTL

//  Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU ops.

---
 rtl/seq_div_r32m_if.sv | 27 ++
 rtl/seq_div_r32m.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seq_div_r32m_if.sv
// Handshake bundle for the sequential RV32M divider: request side
// (in_valid/in_ready with operands and op code), response side
// (out_valid/out_ready with result), plus flush and busy status.
interface seq_div_r32m_if #(
  parameter int DATA_W = 32
) ();
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        div_code;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              busy;

  modport master (
    output flush, in_valid, div_code, dividend, divisor, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, div_code, dividend, divisor, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/seq_div_r32m.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Signed ops divide magnitudes and fix the sign at the end. Divide-by-zero
// and most-negative / -1 produce the RISC-V defined results, optionally
// through a one-cycle early-out that skips the iteration entirely.
module seq_div_r32m #(
  parameter int DATA_W    = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic          clk,
  input  logic          nReset,
  seq_div_r32m_if.slave bus
);

  localparam int                CNT_W     = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] MOST_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [DATA_W:0]   r_rem;     // partial remainder, one bit wider than operands
  logic [DATA_W-1:0] r_quo;     // dividend bits shift out MSB-first, quotient bits shift in
  logic [DATA_W-1:0] r_dvs;     // divisor magnitude
  logic [DATA_W-1:0] r_result;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_rem;
  logic              r_q_neg;
  logic              r_r_neg;
  logic              r_dz;

  // Conditional two's-complement negate; the most-negative value maps onto
  // itself, which read as unsigned is exactly its magnitude 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] f_cneg(input logic [DATA_W-1:0] v,
                                               input logic              neg);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

  logic                     w_accept;
  logic                     w_signed;
  logic                     w_sd;
  logic                     w_sv;
  logic                     w_dz;
  logic                     w_ovf;
  logic                     w_special;
  logic [DATA_W-1:0]        w_spec_res;
  logic signed [DATA_W+1:0] w_shift;
  logic signed [DATA_W+1:0] w_diff;
  logic                     w_ge;
  logic [DATA_W:0]          w_rem_nxt;
  logic [DATA_W-1:0]        w_fix_res;

  assign w_accept  = bus.in_valid && (r_state == S_IDLE) && !bus.flush;
  assign w_signed  = ~bus.div_code[0];
  assign w_sd      = w_signed & bus.dividend[DATA_W-1];
  assign w_sv      = w_signed & bus.divisor[DATA_W-1];
  assign w_dz      = (bus.divisor == '0);
  assign w_ovf     = w_signed && (bus.dividend == MOST_NEG) && (bus.divisor == '1);
  assign w_special = w_dz || w_ovf;

  // Early-out results: x/0 gives all ones, x%0 gives x; MIN/-1 gives MIN, MIN%-1 gives 0.
  assign w_spec_res = w_dz  ? (bus.div_code[1] ? bus.dividend : '1)
                            : (bus.div_code[1] ? '0 : bus.dividend);

  // One restoring step: shift in next dividend bit, trial-subtract divisor.
  assign w_shift   = {r_rem, r_quo[DATA_W-1]};
  assign w_diff    = w_shift - $signed({2'b00, r_dvs});
  assign w_ge      = ~w_diff[DATA_W+1];
  assign w_rem_nxt = w_ge ? w_diff[DATA_W:0] : w_shift[DATA_W:0];

  // The iteration already leaves remainder == dividend for x%0; only the
  // quotient needs overriding since the sign fix would corrupt all-ones.
  assign w_fix_res = r_is_rem ? f_cneg(r_rem[DATA_W-1:0], r_r_neg)
                              : (r_dz ? '1 : f_cneg(r_quo, r_q_neg));

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result    = r_result;

  // State register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (EARLY_OUT && w_special) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == LAST_ITER) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Operand capture on accept, one quotient bit per CALC cycle, result formed in FIX.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_is_rem <= 1'b0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_dz     <= 1'b0;
    end else if (w_accept) begin
      r_is_rem <= bus.div_code[1];
      r_quo    <= f_cneg(bus.dividend, w_sd);
      r_dvs    <= f_cneg(bus.divisor, w_sv);
      r_rem    <= '0;
      r_cnt    <= '0;
      r_q_neg  <= w_sd ^ w_sv;
      r_r_neg  <= w_sd;
      r_dz     <= w_dz;
      if (EARLY_OUT && w_special) begin
        r_result <= w_spec_res;
      end
    end else if (r_state == S_CALC) begin
      r_rem <= w_rem_nxt;
      r_quo <= {r_quo[DATA_W-2:0], w_ge};
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (r_state == S_FIX) begin
      r_result <= w_fix_res;
    end
  end

endmodule
